// File: rtl/sccb_target.sv
// sccb_target: SCCB/I2C target with an internal 256x8 register file.
// Decodes START/STOP, device address, sub-address and data bytes from
// oversampled scl/sda. It drives ACK and read data open-drain through sda_oe.
// Optional feature macro: SCCB_TGT_AUTOINC_EN (burst pointer auto-increment).
module sccb_target #(
  parameter logic [7:0] DEV_ADDR = 8'h60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl,
  input  logic       sda_in,
  output logic       sda,
  output logic       sda_oe,
  output logic       wr_stb,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       busy
);

  typedef enum logic [3:0] {
    IDLE, DEV, DEV_ACK, SUB, SUB_ACK, WDAT, WDAT_ACK, RDAT, RD_ACK, IGNORE
  } state_t;

  logic       scl_s1, scl_s2, scl_h;
  logic       sda_s1, sda_s2, sda_h;
  logic       scl_rise, scl_fall, bus_start, bus_stop;
  state_t     state, state_n;
  logic [3:0] bit_cnt, bit_cnt_n;
  logic [7:0] shift, shift_n;
  logic [7:0] ptr, ptr_n;
  logic [7:0] wr_addr_n, wr_data_n;
  logic       rw, rw_n;
  logic       sda_oe_n, busy_n, wr_stb_n;
  logic       reg_we;
  logic [7:0] rx_byte, rd_byte;
  logic [7:0] regs [256];

  // The pad is only ever pulled low; sda_oe decides whether it is driven.
  assign sda = 1'b0;

  // sda_h lines up with the registered edge flags, so it is the bit under the clock.
  assign rx_byte = {shift[6:0], sda_h};
  assign rd_byte = regs[ptr];

  // Synchronisers and history flops start at the idle-bus level (high).
  // The edge and bus-condition flags are registered, giving 3 clk from pin to flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scl_s1    <= 1'b1;
      scl_s2    <= 1'b1;
      scl_h     <= 1'b1;
      sda_s1    <= 1'b1;
      sda_s2    <= 1'b1;
      sda_h     <= 1'b1;
      scl_rise  <= 1'b0;
      scl_fall  <= 1'b0;
      bus_start <= 1'b0;
      bus_stop  <= 1'b0;
    end else begin
      scl_s1    <= scl;
      scl_s2    <= scl_s1;
      scl_h     <= scl_s2;
      sda_s1    <= sda_in;
      sda_s2    <= sda_s1;
      sda_h     <= sda_s2;
      scl_rise  <= scl_s2 & ~scl_h;
      scl_fall  <= ~scl_s2 & scl_h;
      bus_start <= scl_s2 & scl_h & sda_h & ~sda_s2;
      bus_stop  <= scl_s2 & scl_h & ~sda_h & sda_s2;
    end
  end

  // Protocol state and registered outputs; a reset releases SDA immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      bit_cnt <= 4'd0;
      shift   <= 8'h00;
      ptr     <= 8'h00;
      rw      <= 1'b0;
      sda_oe  <= 1'b0;
      busy    <= 1'b0;
      wr_stb  <= 1'b0;
      wr_addr <= 8'h00;
      wr_data <= 8'h00;
    end else begin
      state   <= state_n;
      bit_cnt <= bit_cnt_n;
      shift   <= shift_n;
      ptr     <= ptr_n;
      rw      <= rw_n;
      sda_oe  <= sda_oe_n;
      busy    <= busy_n;
      wr_stb  <= wr_stb_n;
      wr_addr <= wr_addr_n;
      wr_data <= wr_data_n;
    end
  end

  // Register file has no reset; a read-back always sees the most recent write.
  always_ff @(posedge clk) begin
    if (reg_we) regs[ptr] <= wr_data_n;
  end

  // Next-state logic. START/STOP win over any edge flag in the same cycle.
  // Bits are sampled on scl_rise. SDA is only changed on scl_fall.
  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    shift_n   = shift;
    ptr_n     = ptr;
    rw_n      = rw;
    sda_oe_n  = sda_oe;
    busy_n    = busy;
    wr_stb_n  = 1'b0;
    wr_addr_n = wr_addr;
    wr_data_n = wr_data;
    reg_we    = 1'b0;
    if (bus_start) begin
      state_n   = DEV;
      bit_cnt_n = 4'd0;
      sda_oe_n  = 1'b0;
    end else if (bus_stop) begin
      state_n  = IDLE;
      sda_oe_n = 1'b0;
      busy_n   = 1'b0;
    end else begin
      case (state)
        DEV: if (scl_rise) begin
          shift_n   = rx_byte;
          bit_cnt_n = bit_cnt + 4'd1;
          if (bit_cnt == 4'd7) begin
            bit_cnt_n = 4'd0;
            if (rx_byte[7:1] == DEV_ADDR[7:1]) begin
              state_n = DEV_ACK;
              busy_n  = 1'b1;
              rw_n    = rx_byte[0];
            end else begin
              state_n = IGNORE;
            end
          end
        end
        // The first fall after bit 8 pulls SDA low. The next fall ends the ACK.
        DEV_ACK: if (scl_fall) begin
          if (!sda_oe) begin
            sda_oe_n = 1'b1;
          end else if (rw) begin
            state_n   = RDAT;
            shift_n   = {rd_byte[6:0], 1'b0};
            sda_oe_n  = ~rd_byte[7];
            bit_cnt_n = 4'd1;
          end else begin
            state_n   = SUB;
            sda_oe_n  = 1'b0;
            bit_cnt_n = 4'd0;
          end
        end
        SUB: if (scl_rise) begin
          shift_n   = rx_byte;
          bit_cnt_n = bit_cnt + 4'd1;
          if (bit_cnt == 4'd7) begin
            bit_cnt_n = 4'd0;
            ptr_n     = rx_byte;
            state_n   = SUB_ACK;
          end
        end
        SUB_ACK, WDAT_ACK: if (scl_fall) begin
          if (!sda_oe) begin
            sda_oe_n = 1'b1;
          end else begin
            state_n   = WDAT;
            sda_oe_n  = 1'b0;
            bit_cnt_n = 4'd0;
          end
        end
        WDAT: if (scl_rise) begin
          shift_n   = rx_byte;
          bit_cnt_n = bit_cnt + 4'd1;
          if (bit_cnt == 4'd7) begin
            bit_cnt_n = 4'd0;
            reg_we    = 1'b1;
            wr_stb_n  = 1'b1;
            wr_addr_n = ptr;
            wr_data_n = rx_byte;
            state_n   = WDAT_ACK;
`ifdef SCCB_TGT_AUTOINC_EN
            ptr_n     = ptr + 8'd1;
`endif
          end
        end
        // bit_cnt counts bits already driven. After the 8th bit, the next fall releases the line.
        RDAT: if (scl_fall) begin
          if (bit_cnt == 4'd8) begin
            sda_oe_n = 1'b0;
            state_n  = RD_ACK;
          end else begin
            sda_oe_n  = ~shift[7];
            shift_n   = {shift[6:0], 1'b0};
            bit_cnt_n = bit_cnt + 4'd1;
          end
        end
        // On an initiator ACK, reload with nothing driven yet.
        // The next fall then drives the MSB.
        RD_ACK: if (scl_rise) begin
          if (!sda_h) begin
            state_n   = RDAT;
            bit_cnt_n = 4'd0;
`ifdef SCCB_TGT_AUTOINC_EN
            ptr_n     = ptr + 8'd1;
            shift_n   = regs[ptr_n];
`else
            shift_n   = rd_byte;
`endif
          end else begin
            state_n = IGNORE;
          end
        end
        IDLE, IGNORE: sda_oe_n = 1'b0;
        default: begin
          state_n  = IDLE;
          sda_oe_n = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sccb_target.sv
// tb_sccb_target: directed-vector bench for sccb_target.
// A bit-level bus initiator model drives scl and sda, and sda_in is the wired-AND with the target.
// Build with SCCB_TGT_AUTOINC_EN defined to select the burst expectations.
module tb_sccb_target;

  logic       clk = 1'b0;
  logic       reset;
  logic       scl;
  logic       sda_m;
  logic       sda_bus;
  logic       sda;
  logic       sda_oe;
  logic       wr_stb;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;

  int total = 0;
  int bad = 0;
  int stb_cnt = 0;
  int oe_cnt = 0;
  int busy_cnt = 0;
  logic [7:0] stb_addr_q[$];
  logic [7:0] stb_data_q[$];

  assign sda_bus = sda_m & ~sda_oe;

  sccb_target #(.DEV_ADDR(8'h60)) dut (
    .clk     (clk),
    .reset   (reset),
    .scl     (scl),
    .sda_in  (sda_bus),
    .sda     (sda),
    .sda_oe  (sda_oe),
    .wr_stb  (wr_stb),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .busy    (busy)
  );

  // 10-unit system clock
  always #5 clk = ~clk;

  // Passive monitor: logs every write strobe and counts driven/busy cycles
  always @(negedge clk) begin
    if (wr_stb) begin
      stb_cnt++;
      stb_addr_q.push_back(wr_addr);
      stb_data_q.push_back(wr_data);
    end
    if (sda_oe) oe_cnt++;
    if (busy) busy_cnt++;
  end

  // Watchdog so the run can never hang
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One SCL period: 10 clk low, 10 clk high, data set 3 clk into the low phase
  task automatic clock_bit(input logic v, output logic s);
    wait_clk(3); sda_m = v;
    wait_clk(7); scl = 1'b1;
    wait_clk(5); s = sda_bus;
    wait_clk(5); scl = 1'b0;
  endtask

  task automatic bus_start();
    wait_clk(3); sda_m = 1'b1;
    wait_clk(7); scl = 1'b1;
    wait_clk(10); sda_m = 1'b0;
    wait_clk(10); scl = 1'b0;
  endtask

  task automatic bus_stop(output logic busy_after);
    wait_clk(3); sda_m = 1'b0;
    wait_clk(7); scl = 1'b1;
    wait_clk(10); sda_m = 1'b1;
    wait_clk(4); busy_after = busy;
    wait_clk(10);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) clock_bit(b[i], s);
    clock_bit(1'b1, ack);
  endtask

  task automatic recv_byte(input logic nack, output logic [7:0] b, output logic oe_at_ack);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      clock_bit(1'b1, s);
      b[i] = s;
    end
    wait_clk(3); sda_m = nack;
    wait_clk(7); oe_at_ack = sda_oe; scl = 1'b1;
    wait_clk(10); scl = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; scl = 1'b1; sda_m = 1'b1;
    wait_clk(3);
    total++; if (sda_oe !== 1'b0) begin bad++; $display("[TB] FAIL reset_sda_oe: got %b want 0", sda_oe); end
    total++; if (sda !== 1'b0) begin bad++; $display("[TB] FAIL reset_sda: got %b want 0", sda); end
    total++; if (wr_stb !== 1'b0) begin bad++; $display("[TB] FAIL reset_wr_stb: got %b want 0", wr_stb); end
    total++; if (wr_addr !== 8'h00) begin bad++; $display("[TB] FAIL reset_wr_addr: got %h want 00", wr_addr); end
    total++; if (wr_data !== 8'h00) begin bad++; $display("[TB] FAIL reset_wr_data: got %h want 00", wr_data); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
    reset = 1'b0;
    wait_clk(10);
    total++; if (busy !== 1'b0 || sda_oe !== 1'b0) begin bad++; $display("[TB] FAIL post_reset_idle: got busy=%b oe=%b want 0 0", busy, sda_oe); end
  endtask

  task automatic test_write_basic();
    int base;
    logic a0, a1, a2, b_mid, b_end;
    base = stb_cnt;
    bus_start();
    send_byte(8'h60, a0);
    send_byte(8'h2C, a1);
    send_byte(8'hFF, a2);
    b_mid = busy;
    bus_stop(b_end);
    total++; if (a0 !== 1'b0) begin bad++; $display("[TB] FAIL wr_ack_dev: got %b want 0", a0); end
    total++; if (a1 !== 1'b0) begin bad++; $display("[TB] FAIL wr_ack_sub: got %b want 0", a1); end
    total++; if (a2 !== 1'b0) begin bad++; $display("[TB] FAIL wr_ack_data: got %b want 0", a2); end
    total++; if (b_mid !== 1'b1) begin bad++; $display("[TB] FAIL wr_busy_mid: got %b want 1", b_mid); end
    total++; if (b_end !== 1'b0) begin bad++; $display("[TB] FAIL wr_busy_after_stop: got %b want 0", b_end); end
    total++;
    if (stb_cnt - base !== 1) begin
      bad++; $display("[TB] FAIL wr_stb_count: got %0d want 1", stb_cnt - base);
    end else begin
      total++; if (stb_addr_q[base] !== 8'h2C) begin bad++; $display("[TB] FAIL wr_addr: got %h want 2c", stb_addr_q[base]); end
      total++; if (stb_data_q[base] !== 8'hFF) begin bad++; $display("[TB] FAIL wr_data: got %h want ff", stb_data_q[base]); end
    end
  endtask

  task automatic test_read_back();
    int base;
    logic a0, a1, a2, a3, a4, a5, oe_ack, b_end;
    logic [7:0] rd;
    base = stb_cnt;
    bus_start();
    send_byte(8'h60, a0);
    send_byte(8'h12, a1);
    send_byte(8'h80, a2);
    bus_stop(b_end);
    bus_start();
    send_byte(8'h60, a3);
    send_byte(8'h12, a4);
    bus_start();
    send_byte(8'h61, a5);
    recv_byte(1'b1, rd, oe_ack);
    bus_stop(b_end);
    total++; if ({a0, a1, a2, a3, a4, a5} !== 6'b000000) begin bad++; $display("[TB] FAIL rd_acks: got %b want 000000", {a0, a1, a2, a3, a4, a5}); end
    total++; if (rd !== 8'h80) begin bad++; $display("[TB] FAIL rd_data: got %h want 80", rd); end
    total++; if (oe_ack !== 1'b0) begin bad++; $display("[TB] FAIL rd_release: got oe=%b want 0", oe_ack); end
    total++; if (b_end !== 1'b0) begin bad++; $display("[TB] FAIL rd_busy_after_stop: got %b want 0", b_end); end
    total++; if (stb_cnt - base !== 1) begin bad++; $display("[TB] FAIL rd_stb_count: got %0d want 1", stb_cnt - base); end
  endtask

  task automatic test_addr_mismatch();
    int sb, ob, bb;
    logic a0, a1, a2, b_end;
    sb = stb_cnt; ob = oe_cnt; bb = busy_cnt;
    bus_start();
    send_byte(8'h42, a0);
    send_byte(8'h2C, a1);
    send_byte(8'hFF, a2);
    bus_stop(b_end);
    total++; if (a0 !== 1'b1) begin bad++; $display("[TB] FAIL nm_ack: got %b want 1", a0); end
    total++; if (oe_cnt - ob !== 0) begin bad++; $display("[TB] FAIL nm_sda_oe_cycles: got %0d want 0", oe_cnt - ob); end
    total++; if (stb_cnt - sb !== 0) begin bad++; $display("[TB] FAIL nm_stb_count: got %0d want 0", stb_cnt - sb); end
    total++; if (busy_cnt - bb !== 0) begin bad++; $display("[TB] FAIL nm_busy_cycles: got %0d want 0", busy_cnt - bb); end
  endtask

  task automatic test_burst();
    int base;
    logic a0, a1, a2, a3, a4, oe_ack, b_end;
    logic [7:0] rd;
    logic [7:0] exp_addr [3];
    logic [7:0] exp_data [3];
    logic [7:0] exp_rd;
`ifdef SCCB_TGT_AUTOINC_EN
    exp_addr = '{8'hFE, 8'hFF, 8'h00};
    exp_rd = 8'h11;
`else
    exp_addr = '{8'hFE, 8'hFE, 8'hFE};
    exp_rd = 8'h33;
`endif
    exp_data = '{8'h11, 8'h22, 8'h33};
    base = stb_cnt;
    bus_start();
    send_byte(8'h60, a0);
    send_byte(8'hFE, a1);
    send_byte(8'h11, a2);
    send_byte(8'h22, a3);
    send_byte(8'h33, a4);
    bus_stop(b_end);
    total++; if ({a0, a1, a2, a3, a4} !== 5'b00000) begin bad++; $display("[TB] FAIL burst_acks: got %b want 00000", {a0, a1, a2, a3, a4}); end
    total++;
    if (stb_cnt - base !== 3) begin
      bad++; $display("[TB] FAIL burst_stb_count: got %0d want 3", stb_cnt - base);
    end else begin
      for (int i = 0; i < 3; i++) begin
        total++; if (stb_addr_q[base + i] !== exp_addr[i]) begin bad++; $display("[TB] FAIL burst_addr%0d: got %h want %h", i, stb_addr_q[base + i], exp_addr[i]); end
        total++; if (stb_data_q[base + i] !== exp_data[i]) begin bad++; $display("[TB] FAIL burst_data%0d: got %h want %h", i, stb_data_q[base + i], exp_data[i]); end
      end
    end
    bus_start();
    send_byte(8'h60, a0);
    send_byte(8'hFE, a1);
    bus_start();
    send_byte(8'h61, a2);
    recv_byte(1'b1, rd, oe_ack);
    bus_stop(b_end);
    total++; if (rd !== exp_rd) begin bad++; $display("[TB] FAIL burst_readback_fe: got %h want %h", rd, exp_rd); end
  endtask

  task automatic test_reset_mid_read();
    logic a0, a1, a2, s;
    bus_start();
    send_byte(8'h60, a0);
    send_byte(8'h12, a1);
    bus_start();
    send_byte(8'h61, a2);
    for (int i = 0; i < 4; i++) clock_bit(1'b1, s);
    wait_clk(3); sda_m = 1'b1;
    wait_clk(7); scl = 1'b1;
    wait_clk(5);
    total++; if (sda_oe !== 1'b1) begin bad++; $display("[TB] FAIL rst_rd_driving: got oe=%b want 1", sda_oe); end
    reset = 1'b1;
    #1;
    total++; if (sda_oe !== 1'b0) begin bad++; $display("[TB] FAIL rst_rd_release: got oe=%b want 0", sda_oe); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL rst_rd_busy: got %b want 0", busy); end
    wait_clk(3); scl = 1'b0;
    wait_clk(2); reset = 1'b0;
    wait_clk(5);
  endtask

  task automatic test_reset_mid_write();
    int base;
    logic a0, a1, a2, a3, a4, s, b_end;
    base = stb_cnt;
    bus_start();
    send_byte(8'h60, a0);
    send_byte(8'h20, a1);
    for (int i = 0; i < 4; i++) clock_bit(1'b1, s);
    wait_clk(3); sda_m = 1'b1;
    wait_clk(7); scl = 1'b1;
    wait_clk(5);
    reset = 1'b1;
    #1;
    total++; if (sda_oe !== 1'b0) begin bad++; $display("[TB] FAIL rst_wr_oe: got %b want 0", sda_oe); end
    wait_clk(3); scl = 1'b0;
    wait_clk(2); reset = 1'b0;
    wait_clk(5);
    total++; if (stb_cnt - base !== 0) begin bad++; $display("[TB] FAIL rst_wr_no_stb: got %0d want 0", stb_cnt - base); end
    base = stb_cnt;
    bus_start();
    send_byte(8'h60, a2);
    send_byte(8'h05, a3);
    send_byte(8'h00, a4);
    bus_stop(b_end);
    total++; if ({a2, a3, a4} !== 3'b000) begin bad++; $display("[TB] FAIL rst_after_acks: got %b want 000", {a2, a3, a4}); end
    total++;
    if (stb_cnt - base !== 1) begin
      bad++; $display("[TB] FAIL rst_after_stb_count: got %0d want 1", stb_cnt - base);
    end else begin
      total++; if (stb_addr_q[base] !== 8'h05 || stb_data_q[base] !== 8'h00) begin bad++; $display("[TB] FAIL rst_after_write: got %h/%h want 05/00", stb_addr_q[base], stb_data_q[base]); end
    end
  endtask

  task automatic test_start_mid_wdat();
    int base;
    logic a0, a1, a2, a3, a4, s, b_end;
    base = stb_cnt;
    bus_start();
    send_byte(8'h60, a0);
    send_byte(8'h30, a1);
    clock_bit(1'b1, s);
    clock_bit(1'b0, s);
    wait_clk(3); sda_m = 1'b1;
    wait_clk(7); scl = 1'b1;
    wait_clk(10); sda_m = 1'b0;
    wait_clk(10); scl = 1'b0;
    total++; if (stb_cnt - base !== 0) begin bad++; $display("[TB] FAIL rs_partial_stb: got %0d want 0", stb_cnt - base); end
    send_byte(8'h60, a2);
    send_byte(8'h31, a3);
    send_byte(8'hAA, a4);
    bus_stop(b_end);
    total++; if ({a2, a3, a4} !== 3'b000) begin bad++; $display("[TB] FAIL rs_acks: got %b want 000", {a2, a3, a4}); end
    total++;
    if (stb_cnt - base !== 1) begin
      bad++; $display("[TB] FAIL rs_stb_count: got %0d want 1", stb_cnt - base);
    end else begin
      total++; if (stb_addr_q[base] !== 8'h31 || stb_data_q[base] !== 8'hAA) begin bad++; $display("[TB] FAIL rs_write: got %h/%h want 31/aa", stb_addr_q[base], stb_data_q[base]); end
    end
  endtask

  // Run every scenario in order and print the summary line
  initial begin
    $display("[TB] sccb_target bench start");
    test_reset();
    test_write_basic();
    test_read_back();
    test_addr_mismatch();
    test_burst();
    test_reset_mid_read();
    test_reset_mid_write();
    test_start_mid_wdat();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
